// File: rtl/fnd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: hex decode, leading-zero blanking,
// per-digit blink, 8-level PWM brightness and a frame-completion strobe.
module fnd_scan_ctrl #(
    parameter int unsigned N_DIGIT      = 6,
    parameter int unsigned SCAN_DIV     = 5000,
    parameter int unsigned BLINK_FRAMES = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*N_DIGIT-1:0]   i_digits,
    input  logic [N_DIGIT-1:0]     i_dp,
    input  logic [N_DIGIT-1:0]     i_blink,
    input  logic                   i_lzb,
    input  logic [2:0]             i_bright,
    output logic [6:0]             o_seg,
    output logic                   o_seg_dp,
    output logic [N_DIGIT-1:0]     o_seg_enb,
    output logic                   o_frame_tick
);

    localparam int unsigned SLOT  = SCAN_DIV / 8;
    localparam int unsigned SUB_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int unsigned IDX_W = $clog2(N_DIGIT);
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // The prescaler is kept as {phase, sub}: pre = phase*SLOT + sub, so the PWM
    // phase falls out directly without a divider.
    logic [SUB_W-1:0] sub_q;
    logic [2:0]       phase_q;
    logic [IDX_W-1:0] idx_q;
    logic [FRM_W-1:0] frame_q;
    logic             blink_state_q;
    logic             wrap_q;

    logic sub_end;
    logic slot_end;
    logic frame_wrap;

    assign sub_end    = (sub_q == SUB_W'(SLOT - 1));
    assign slot_end   = sub_end && (phase_q == 3'd7);
    assign frame_wrap = slot_end && (idx_q == IDX_W'(N_DIGIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q         <= '0;
            phase_q       <= '0;
            idx_q         <= '0;
            frame_q       <= '0;
            blink_state_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            if (sub_end) begin
                sub_q   <= '0;
                phase_q <= phase_q + 3'd1;
            end else begin
                sub_q <= sub_q + SUB_W'(1);
            end

            if (slot_end) begin
                if (idx_q == IDX_W'(N_DIGIT - 1)) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end

            if (frame_wrap) begin
                if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_q       <= '0;
                    blink_state_q <= ~blink_state_q;
                end else begin
                    frame_q <= frame_q + FRM_W'(1);
                end
            end

            // High exactly while the state sits on digit 0, pre 0 of a new frame.
            wrap_q <= frame_wrap;
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1110011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    // upper_zero[k]: digits N_DIGIT-1..k are all zero.
    logic [N_DIGIT-1:0] upper_zero;

    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int k = N_DIGIT - 1; k >= 0; k--) begin
            acc           = acc && (i_digits[4*k +: 4] == 4'h0);
            upper_zero[k] = acc;
        end
    end

    logic [3:0]         cur_digit;
    logic               cur_dp;
    logic               cur_blink;
    logic               cur_upper_zero;
    logic [N_DIGIT-1:0] enb_sel;

    always_comb begin
        cur_digit      = 4'h0;
        cur_dp         = 1'b0;
        cur_blink      = 1'b0;
        cur_upper_zero = 1'b0;
        enb_sel        = '1;
        for (int k = 0; k < N_DIGIT; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_digit      = i_digits[4*k +: 4];
                cur_dp         = i_dp[k];
                cur_blink      = i_blink[k];
                cur_upper_zero = upper_zero[k];
                enb_sel[k]     = 1'b0;
            end
        end
    end

    logic               dark;
    logic               blank;
    logic [6:0]         seg_d;
    logic               seg_dp_d;
    logic [N_DIGIT-1:0] seg_enb_d;

    always_comb begin
        dark      = (phase_q > i_bright) || (blink_state_q && cur_blink);
        blank     = i_lzb && (idx_q != '0) && cur_upper_zero;
        seg_d     = 7'b0;
        seg_dp_d  = 1'b0;
        seg_enb_d = '1;
        if (!dark) begin
            seg_enb_d = enb_sel;
            seg_dp_d  = cur_dp;
            seg_d     = blank ? 7'b0 : hex_glyph(cur_digit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_seg        <= 7'b0;
            o_seg_dp     <= 1'b0;
            o_seg_enb    <= '1;
            o_frame_tick <= 1'b0;
        end else begin
            o_seg        <= seg_d;
            o_seg_dp     <= seg_dp_d;
            o_seg_enb    <= seg_enb_d;
            o_frame_tick <= wrap_q;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: expected outputs come from a closed-form
// model of the scan position derived from the cycle count since reset release.
module tb_fnd_scan_ctrl;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int BF = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp;
    logic [N-1:0]   blink;
    logic           lzb;
    logic [2:0]     bright;
    logic [6:0]     seg;
    logic           seg_dp;
    logic [N-1:0]   seg_enb;
    logic           frame_tick;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] enb;
        logic         tick;
    } out_t;

    out_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ticks    = 0;

    fnd_scan_ctrl #(
        .N_DIGIT      (N),
        .SCAN_DIV     (D),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_digits     (digits),
        .i_dp         (dp),
        .i_blink      (blink),
        .i_lzb        (lzb),
        .i_bright     (bright),
        .o_seg        (seg),
        .o_seg_dp     (seg_dp),
        .o_seg_enb    (seg_enb),
        .o_frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        return t[d];
    endfunction

    // Output expected after the edge that leaves state number c (c=0: first edge).
    function automatic out_t model(input int c);
        int   pre, idx, phase, frame;
        logic bs, dark, blank;
        out_t o;
        pre   = c % D;
        idx   = (c / D) % N;
        phase = pre / (D / 8);
        frame = c / (N * D);
        bs    = ((frame / BF) % 2) == 1;
        dark  = (phase > int'(bright)) || (bs && blink[idx]);
        blank = lzb && (idx > 0) && ((digits >> (4 * idx)) == '0);
        o      = '0;
        o.enb  = '1;
        o.tick = (pre == 0) && (idx == 0) && (frame > 0);
        if (!dark) begin
            o.enb = ~(N'(1) << idx);
            o.dp  = dp[idx];
            o.seg = blank ? 7'b0 : glyph(digits[4*idx +: 4]);
        end
        return o;
    endfunction

    task automatic step(input int n, input bit rnd);
        out_t e;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                bright = 3'($urandom_range(0, 7));
                digits = 16'($urandom);
                dp     = 4'($urandom);
            end
            exp_q.push_back(model(cyc));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check("seg", 32'(seg), 32'(e.seg));
            check("dp", 32'(seg_dp), 32'(e.dp));
            check("enb", 32'(seg_enb), 32'(e.enb));
            check("tick", 32'(frame_tick), 32'(e.tick));
            if (frame_tick) ticks++;
            cyc++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h0);
        check({tag, "_dp"}, 32'(seg_dp), 32'h0);
        check({tag, "_enb"}, 32'(seg_enb), 32'hF);
        check({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        digits = 16'h1234;
        dp     = '0;
        blink  = '0;
        lzb    = 1'b0;
        bright = 3'd7;
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        step(64, 0);                      // scan order and decode of 1234
        digits = 16'hABCF;
        step(64, 0);
        digits = 16'h0040; lzb = 1'b1; dp = 4'b0100;
        step(64, 0);
        digits = 16'h0000; dp = 4'b0000;
        step(64, 0);
        digits = 16'h1234; lzb = 1'b0;
        bright = 3'd1;
        step(64, 0);
        bright = 3'd0;
        step(64, 0);
        bright = 3'd7; blink = 4'b0001;
        step(384, 0);                     // several blink half-periods
        step(128, 1);                     // brightness and data changing every cycle
        check("tick_count", 32'(ticks), 32'((cyc - 1) / (N * D)));

        bright = 3'd7; digits = 16'h5678; dp = 4'b1010;
        while ((cyc % (N * D)) != 40) step(1, 0);
        rst_n = 1'b0;                     // mid digit-2 slot
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        check_reset_vals("midrst_hold");
        rst_n = 1'b1;
        cyc   = 0;
        ticks = 0;
        exp_q.delete();
        step(300, 0);
        check("tick_after_rst", 32'(ticks), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
